// File: rtl/cache_pkg.sv
// Shared FSM state type, PLRU vector type and address-field helpers for the
// N-way write-through data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } cache_state_e;

    localparam int MAX_WAYS = 8;

    // Tree pseudo-LRU bits of one set; a WAYS-way cache uses the low WAYS-1 bits.
    typedef logic [MAX_WAYS-2:0] plru_t;

    function automatic int offset_lsb();
        return 2;
    endfunction

    function automatic int index_lsb(input int word_bits);
        return word_bits + 2;
    endfunction

    function automatic int tag_lsb(input int set_bits, input int word_bits);
        return set_bits + word_bits + 2;
    endfunction

    function automatic int line_w(input int word_bits);
        return 32 << word_bits;
    endfunction

endpackage

// File: rtl/cache_nway_ctrl_if.sv
// CPU-side and SRAM-side buses of the N-way data cache.
interface cache_cpu_if;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    modport master (output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata,
                    input  cpu_rdata, cpu_stall);
    modport slave  (input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata,
                    output cpu_rdata, cpu_stall);
endinterface

// A request (mem_rd_req or mem_wr_req, never both) stays high with mem_addr and
// mem_wdata stable until the cycle in which mem_ready pulses; that cycle completes it.
interface cache_mem_if #(parameter int LINE_W = 64);
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;

    modport master (output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set: victim way from the current bits, and the bits
// after touching i_way. A bit value of 0 steers the victim to the lower half.
module cache_plru
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  plru_t            i_plru,
    input  logic [WAY_W-1:0] i_way,
    output logic [WAY_W-1:0] o_victim,
    output plru_t            o_plru_next
);
    localparam int LEVELS = $clog2(WAYS);

    always_comb begin
        int node;
        node     = 0;
        o_victim = '0;
        for (int l = 0; l < LEVELS; l++) begin
            o_victim = WAY_W'({o_victim, i_plru[node]});
            node     = 2 * node + 1 + int'(i_plru[node]);
        end
        // Point every node on the touched path away from the touched way.
        o_plru_next = i_plru;
        node        = 0;
        for (int l = LEVELS - 1; l >= 0; l--) begin
            o_plru_next[node] = ~i_way[l];
            node              = 2 * node + 1 + int'(i_way[l]);
        end
    end

endmodule

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative write-through, no-write-allocate data cache controller.
// Define CACHE_STATS_EN to add saturating stat_hits / stat_misses counters.
module cache_nway_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SET_BITS  = 6,
    parameter int WORD_BITS = 1,
    parameter int TAG_W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    cache_cpu_if.slave   cpu,
    cache_mem_if.master  mem,
    output cache_state_e o_dbg_state
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);
    localparam int SETS      = 1 << SET_BITS;
    localparam int LINE_BITS = line_w(WORD_BITS);
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WSEL_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int OFF_LSB   = offset_lsb();
    localparam int IDX_LSB   = index_lsb(WORD_BITS);
    localparam int TAG_LSB   = tag_lsb(SET_BITS, WORD_BITS);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << IDX_LSB) - 32'd1);

    cache_state_e         r_state;
    logic [TAG_W-1:0]     r_tag   [WAYS][SETS];
    logic [LINE_BITS-1:0] r_data  [WAYS][SETS];
    logic [SETS-1:0]      r_valid [WAYS];
    plru_t                r_plru  [SETS];
    logic                 r_wr_done;

    logic [SET_BITS-1:0]  w_index;
    logic [TAG_W-1:0]     w_tag;
    logic [WSEL_W-1:0]    w_word;
    logic                 w_hit, w_rd_req, w_wr_req, w_rd_hit;
    logic [WAY_W-1:0]     w_hit_way, w_fill_way, w_touch_way, w_plru_victim;
    logic [LINE_BITS-1:0] w_hit_line, w_merged;
    logic [31:0]          w_hit_word;
    plru_t                w_plru_next;

    assign w_index = SET_BITS'(cpu.cpu_addr >> IDX_LSB);
    assign w_tag   = TAG_W'(cpu.cpu_addr >> TAG_LSB);
    assign w_word  = (WORD_BITS > 0) ? WSEL_W'(cpu.cpu_addr >> OFF_LSB) : '0;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_index] && (r_tag[w][w_index] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit_line = r_data[w_hit_way][w_index];
    assign w_hit_word = 32'(w_hit_line >> {w_word, 5'd0});

    always_comb begin
        w_merged = w_hit_line;
        w_merged[{w_word, 5'd0} +: 32] = cpu.cpu_wdata;
    end

    // r_wr_done marks the cycle after a store completes, so the still-held store
    // retires without being issued a second time.
    assign w_wr_req = cpu.cpu_wr_en && !r_wr_done;
    assign w_rd_req = cpu.cpu_rd_en && !cpu.cpu_wr_en;
    assign w_rd_hit = (r_state == IDLE) && w_rd_req && w_hit;

    assign cpu.cpu_rdata = w_rd_hit ? w_hit_word : 32'd0;
    assign cpu.cpu_stall = (r_state != IDLE) || w_wr_req || (w_rd_req && !w_hit);
    assign o_dbg_state   = r_state;

    generate
        if (WAYS > 1) begin : g_plru
            cache_plru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
                .i_plru      (r_plru[w_index]),
                .i_way       (w_touch_way),
                .o_victim    (w_plru_victim),
                .o_plru_next (w_plru_next)
            );
        end else begin : g_direct
            assign w_plru_victim = '0;
            assign w_plru_next   = '0;
        end
    endgenerate

    always_comb begin
        w_fill_way = w_plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_index]) w_fill_way = WAY_W'(w);
        end
    end

    assign w_touch_way = (r_state == REFILL) ? w_fill_way : w_hit_way;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wr_done      <= 1'b0;
            mem.mem_rd_req <= 1'b0;
            mem.mem_wr_req <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_wr_req) begin
                        r_state        <= WRITE;
                        mem.mem_wr_req <= 1'b1;
                        mem.mem_addr   <= cpu.cpu_addr;
                        mem.mem_wdata  <= cpu.cpu_wdata;
                    end else if (w_rd_req && !w_hit) begin
                        r_state        <= REFILL;
                        mem.mem_rd_req <= 1'b1;
                        mem.mem_addr   <= cpu.cpu_addr & LINE_MASK;
                    end else if (w_rd_hit) begin
                        r_plru[w_index] <= w_plru_next;
                    end
                end
                REFILL: begin
                    if (mem.mem_ready) begin
                        r_data[w_fill_way][w_index]  <= mem.mem_rdata;
                        r_tag[w_fill_way][w_index]   <= w_tag;
                        r_valid[w_fill_way][w_index] <= 1'b1;
                        r_plru[w_index]              <= w_plru_next;
                        mem.mem_rd_req               <= 1'b0;
                        r_state                      <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        if (w_hit) begin
                            r_data[w_hit_way][w_index] <= w_merged;
                            r_plru[w_index]            <= w_plru_next;
                        end
                        mem.mem_wr_req <= 1'b0;
                        r_wr_done      <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_stat_hits, r_stat_misses;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else begin
            if (w_rd_hit && (r_stat_hits != 32'hFFFF_FFFF))
                r_stat_hits <= r_stat_hits + 32'd1;
            if ((r_state == IDLE) && !w_wr_req && w_rd_req && !w_hit &&
                (r_stat_misses != 32'hFFFF_FFFF))
                r_stat_misses <= r_stat_misses + 32'd1;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl: refill latency, PLRU eviction, write-through
// stores, no-allocate store misses and reset during a refill (stats with CACHE_STATS_EN).
`timescale 1ns/1ps
module tb_cache_nway_ctrl;
    import cache_pkg::*;

    localparam int SRAM_LAT = 3;
    localparam int MAX_WAIT = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_cpu_if                cpu_if ();
    cache_mem_if #(.LINE_W(64)) mem_if ();
    cache_state_e               dbg_state;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    cache_nway_ctrl #(.WAYS(2), .SET_BITS(6), .WORD_BITS(1), .TAG_W(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu_if),
        .mem         (mem_if),
        .o_dbg_state (dbg_state)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic sram_busy = 1'b0;
    int   sram_cnt  = 0;

    function automatic logic [63:0] sram_line(input logic [31:0] a);
        if (a == 32'h0000_0100) return 64'h22222222_11111111;
        return {32'hA500_0000 | a, 32'h5A00_0000 | a};
    endfunction

    initial begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = '0;
    end

    // Requests are seen for SRAM_LAT cycles, then mem_ready pulses on the next one.
    always @(posedge clk) begin
        #1;
        mem_if.mem_ready = 1'b0;
        if (sram_busy) begin
            sram_cnt++;
            if (sram_cnt > SRAM_LAT) begin
                mem_if.mem_ready = 1'b1;
                mem_if.mem_rdata = sram_line(mem_if.mem_addr);
                sram_busy        = 1'b0;
            end
        end else if (mem_if.mem_rd_req || mem_if.mem_wr_req) begin
            sram_busy = 1'b1;
            sram_cnt  = 1;
        end
    end

    // ---------------- request monitor ----------------
    int          rd_req_cnt = 0, wr_req_cnt = 0, both_cnt = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;

    always @(negedge clk) begin
        if (mem_if.mem_rd_req && !prev_rd) begin
            rd_req_cnt++;
            last_rd_addr = mem_if.mem_addr;
        end
        if (mem_if.mem_wr_req && !prev_wr) begin
            wr_req_cnt++;
            last_wr_addr = mem_if.mem_addr;
            last_wr_data = mem_if.mem_wdata;
        end
        if (mem_if.mem_rd_req && mem_if.mem_wr_req) both_cnt++;
        prev_rd = mem_if.mem_rd_req;
        prev_wr = mem_if.mem_wr_req;
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input int exp_stalls);
        int stalls = 0;
        cpu_if.cpu_addr  = addr;
        cpu_if.cpu_rd_en = 1'b1;
        cpu_if.cpu_wr_en = 1'b0;
        exp_q.push_back(exp_data);
        forever begin
            @(negedge clk);
            if (!cpu_if.cpu_stall || stalls >= MAX_WAIT) break;
            stalls++;
        end
        check_eq({tag, "_stalls"}, stalls, exp_stalls);
        check_eq({tag, "_rdata"}, cpu_if.cpu_rdata, exp_q.pop_front());
        @(posedge clk); #1;
        cpu_if.cpu_rd_en = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input int exp_stalls);
        int stalls = 0;
        cpu_if.cpu_addr  = addr;
        cpu_if.cpu_wdata = data;
        cpu_if.cpu_wr_en = 1'b1;
        cpu_if.cpu_rd_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!cpu_if.cpu_stall || stalls >= MAX_WAIT) break;
            stalls++;
        end
        check_eq({tag, "_stalls"}, stalls, exp_stalls);
        @(posedge clk); #1;
        cpu_if.cpu_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        cpu_if.cpu_rd_en = 1'b0;
        cpu_if.cpu_wr_en = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_eq("rst_stall", 32'(cpu_if.cpu_stall), 32'd0);
        check_eq("rst_rd_req", 32'(mem_if.mem_rd_req), 32'd0);
        check_eq("rst_wr_req", 32'(mem_if.mem_wr_req), 32'd0);
        check_eq("rst_rdata", cpu_if.cpu_rdata, 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;

        // First refill, then the neighbouring word hits with no stall.
        do_load("ld100", 32'h0000_0100, 32'h1111_1111, 5);
        check_eq("ld100_rdreqs", rd_req_cnt, 32'd1);
        check_eq("ld100_addr", last_rd_addr, 32'h0000_0100);
        do_load("ld104", 32'h0000_0104, 32'h2222_2222, 0);
        check_eq("ld104_rdreqs", rd_req_cnt, 32'd1);
        @(negedge clk);
        check_eq("idle_rdata", cpu_if.cpu_rdata, 32'd0);
        check_eq("idle_stall", 32'(cpu_if.cpu_stall), 32'd0);
        @(posedge clk); #1;

        // Three tags in set 0x20: the third evicts the 0x0100 line.
        do_load("ld2100", 32'h0000_2100, 32'h5A00_2100, 5);
        do_load("ld4104", 32'h0000_4104, 32'hA500_4100, 5);
        check_eq("ld4104_addr", last_rd_addr, 32'h0000_4100);
        do_load("re2100", 32'h0000_2100, 32'h5A00_2100, 0);
        do_load("re100", 32'h0000_0100, 32'h1111_1111, 5);
        check_eq("evict_rdreqs", rd_req_cnt, 32'd4);

        // Store to a cached word: write-through and merge.
        do_store("st104", 32'h0000_0104, 32'hDEAD_BEEF, 5);
        check_eq("st104_wrreqs", wr_req_cnt, 32'd1);
        check_eq("st104_addr", last_wr_addr, 32'h0000_0104);
        check_eq("st104_data", last_wr_data, 32'hDEAD_BEEF);
        do_load("ld104b", 32'h0000_0104, 32'hDEAD_BEEF, 0);
        do_load("ld100b", 32'h0000_0100, 32'h1111_1111, 0);
        check_eq("st104_rdreqs", rd_req_cnt, 32'd4);

        // Store miss: no allocation, so the following load refills.
        do_store("st8000", 32'h0000_8000, 32'h1234_5678, 5);
        check_eq("st8000_wrreqs", wr_req_cnt, 32'd2);
        check_eq("st8000_addr", last_wr_addr, 32'h0000_8000);
        do_load("ld8000", 32'h0000_8000, 32'h5A00_8000, 5);
        check_eq("ld8000_rdreqs", rd_req_cnt, 32'd5);

        // Reset in the second REFILL cycle; the late mem_ready must be ignored.
        cpu_if.cpu_addr  = 32'h0000_A008;
        cpu_if.cpu_rd_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mid_state", 32'(dbg_state), 32'(REFILL));
        check_eq("mid_rd_req", 32'(mem_if.mem_rd_req), 32'd1);
        #4;
        rst              = 1'b1;
        cpu_if.cpu_rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_rd_req", 32'(mem_if.mem_rd_req), 32'd0);
        check_eq("rstmid_stall", 32'(cpu_if.cpu_stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("late_ready_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_load("ldA008", 32'h0000_A008, 32'h5A00_A008, 5);
        check_eq("ldA008_addr", last_rd_addr, 32'h0000_A008);

`ifdef CACHE_STATS_EN
        do_load("ldC010", 32'h0000_C010, 32'h5A00_C010, 5);
        do_load("ldE018", 32'h0000_E018, 32'h5A00_E018, 5);
        do_load("ldA00C", 32'h0000_A00C, 32'hA500_A008, 0);
        do_load("ldC014", 32'h0000_C014, 32'hA500_C010, 0);
        check_eq("stat_misses", stat_misses, 32'd3);
        check_eq("stat_hits", stat_hits, 32'd5);
`endif

        check_eq("req_exclusive", both_cnt, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
